// File: rtl/pipeline_trace_buffer.sv
// Trace capture for the 8-bit pipelined core: circular buffer frozen POST_CNT entries after a trigger.
// Capture writes land one edge after sampling; reads return one cycle after rd_req, one entry per cycle, no stall.
module pipeline_trace_buffer #(
  parameter int DATA_W   = 8,
  parameter int INS_W    = 20,
  parameter int DEPTH    = 16,
  parameter int PTR_W    = 4,
  parameter int POST_CNT = 4,
  parameter int TRIG_IRQ = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      step,
  input  logic [DATA_W-1:0]         trig_addr,
  input  logic [DATA_W-1:0]         cur_addr,
  input  logic [INS_W-1:0]          ins,
  input  logic [DATA_W-1:0]         ans_wb,
  input  logic                      interrupt,
  input  logic                      rd_req,
  output logic                      rd_valid,
  output logic [INS_W+2*DATA_W:0]   rd_data,
  output logic                      armed,
  output logic                      done,
  output logic                      wrapped,
  output logic [PTR_W:0]            count
);

  localparam int ENTRY_W = INS_W + 2*DATA_W + 1;
  localparam logic [PTR_W:0]   L_DEPTH   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   L_ONE_C   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] L_ONE_P   = PTR_W'(1);
  localparam logic [PTR_W-1:0] L_POST    = PTR_W'(POST_CNT);
  localparam bit               L_NO_POST = (POST_CNT == 0);
  localparam bit               L_IRQ_EN  = (TRIG_IRQ != 0);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

  state_t               r_state;
  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_post_left;
  logic [PTR_W:0]       r_count;
  logic [PTR_W:0]       r_remaining;
  logic                 r_rd_valid;
  logic [ENTRY_W-1:0]   r_rd_data;
  logic                 r_armed;
  logic                 r_done;
  logic                 r_wrapped;

  logic                 w_capture;
  logic                 w_trig;
  logic                 w_full;
  logic [PTR_W:0]       w_count_nxt;
  logic [PTR_W-1:0]     w_rd_ptr;
  logic [ENTRY_W-1:0]   w_entry;
  logic                 w_rd_fire;

  assign w_capture   = step && !arm && !reset && (r_state == S_ARMED || r_state == S_POST);
  assign w_trig      = (cur_addr == trig_addr) || (L_IRQ_EN && interrupt);
  assign w_full      = (r_count == L_DEPTH);
  assign w_count_nxt = w_full ? r_count : r_count + L_ONE_C;
  assign w_entry     = {interrupt, cur_addr, ans_wb, ins};
  assign w_rd_fire   = rd_req && (r_state == S_DONE) && (r_remaining != '0);

  // Oldest unread entry sits 'remaining' slots behind the write pointer; a full
  // buffer has remaining==DEPTH, whose low bits are zero, so it lands on wr_ptr.
  assign w_rd_ptr = r_wr_ptr - r_remaining[PTR_W-1:0];

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_post_left <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_armed     <= 1'b0;
      r_done      <= 1'b0;
      r_wrapped   <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (arm) begin
        r_state     <= S_ARMED;
        r_wr_ptr    <= '0;
        r_post_left <= '0;
        r_count     <= '0;
        r_remaining <= '0;
        r_armed     <= 1'b1;
        r_done      <= 1'b0;
        r_wrapped   <= 1'b0;
      end else begin
        case (r_state)
          S_ARMED, S_POST: begin
            if (step) begin
              r_wr_ptr <= r_wr_ptr + L_ONE_P;
              r_count  <= w_count_nxt;
              if (w_full) begin
                r_wrapped <= 1'b1;
              end
              if (r_state == S_ARMED) begin
                if (w_trig) begin
                  if (L_NO_POST) begin
                    r_state     <= S_DONE;
                    r_armed     <= 1'b0;
                    r_done      <= 1'b1;
                    r_remaining <= w_count_nxt;
                  end else begin
                    r_state     <= S_POST;
                    r_post_left <= L_POST;
                  end
                end
              end else begin
                // Triggers seen here are ignored; only the post countdown matters.
                r_post_left <= r_post_left - L_ONE_P;
                if (r_post_left == L_ONE_P) begin
                  r_state     <= S_DONE;
                  r_armed     <= 1'b0;
                  r_done      <= 1'b1;
                  r_remaining <= w_count_nxt;
                end
              end
            end
          end
          S_DONE: begin
            if (w_rd_fire) begin
              r_rd_data   <= r_mem[w_rd_ptr];
              r_rd_valid  <= 1'b1;
              r_remaining <= r_remaining - L_ONE_C;
              if (r_remaining == L_ONE_C) begin
                r_state   <= S_IDLE;
                r_done    <= 1'b0;
                r_count   <= '0;
                r_wrapped <= 1'b0;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign armed    = r_armed;
  assign done     = r_done;
  assign wrapped  = r_wrapped;
  assign count    = r_count;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Bench for pipeline_trace_buffer: table of capture scenarios plus hand-written corner sequences.
module tb_pipeline_trace_buffer;

  localparam int DW = 8;
  localparam int IW = 20;
  localparam int D  = 8;
  localparam int PW = 3;
  localparam int EW = IW + 2*DW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, arm, step, interrupt, rd_req;
  logic [DW-1:0] trig_addr, cur_addr, ans_wb;
  logic [IW-1:0] ins;

  logic          rd_valid, armed, done, wrapped;
  logic [EW-1:0] rd_data;
  logic [PW:0]   count;
  logic          rd_valid2, armed2, done2, wrapped2;
  logic [EW-1:0] rd_data2;
  logic [PW:0]   count2;

  pipeline_trace_buffer #(.DATA_W(DW), .INS_W(IW), .DEPTH(D), .PTR_W(PW), .POST_CNT(3), .TRIG_IRQ(0)) u_dut (
    .clk(clk), .reset(reset), .arm(arm), .step(step), .trig_addr(trig_addr), .cur_addr(cur_addr),
    .ins(ins), .ans_wb(ans_wb), .interrupt(interrupt), .rd_req(rd_req), .rd_valid(rd_valid),
    .rd_data(rd_data), .armed(armed), .done(done), .wrapped(wrapped), .count(count));

  pipeline_trace_buffer #(.DATA_W(DW), .INS_W(IW), .DEPTH(D), .PTR_W(PW), .POST_CNT(0), .TRIG_IRQ(1)) u_irq (
    .clk(clk), .reset(reset), .arm(arm), .step(step), .trig_addr(trig_addr), .cur_addr(cur_addr),
    .ins(ins), .ans_wb(ans_wb), .interrupt(interrupt), .rd_req(rd_req), .rd_valid(rd_valid2),
    .rd_data(rd_data2), .armed(armed2), .done(done2), .wrapped(wrapped2), .count(count2));

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] sb[$];
  logic [EW-1:0] sb2[$];
  logic [EW-1:0] last_exp;

  typedef struct {
    logic [7:0] trig;
    bit         toggle;
    int         cycles;
    int         cnt;
    bit         wrap;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1; step = 1'b0; rd_req = 1'b0;
    tick();
    arm = 1'b0;
    sb.delete();
    sb2.delete();
    chk("arm_armed", armed, 1);
    chk("arm_count", count, 0);
    chk("arm_done", done, 0);
  endtask

  // Drives one address per cycle until done rises; the model keeps the newest D captured entries.
  task automatic capture(input bit toggle, output int cyc);
    logic [EW-1:0] e;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      cur_addr  = cyc[7:0];
      ins       = IW'($urandom);
      ans_wb    = DW'($urandom);
      interrupt = 1'b0;
      step      = toggle ? ((cyc % 2) == 0) : 1'b1;
      e = {interrupt, cur_addr, ans_wb, ins};
      tick();
      if (step) begin
        sb.push_back(e);
        if (sb.size() > D) void'(sb.pop_front());
      end
      cyc++;
    end
    step = 1'b0;
  endtask

  task automatic read_n(input int n);
    logic [EW-1:0] exp;
    for (int i = 0; i < n; i++) begin
      rd_req = 1'b1;
      tick();
      chk("rd_valid", rd_valid, 1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_sb_empty actual=entry required=none");
      end else begin
        exp = sb.pop_front();
        chk("rd_data", rd_data, exp);
        last_exp = exp;
      end
    end
    rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [EW-1:0] e;

    reset = 1'b1; arm = 1'b0; step = 1'b0; interrupt = 1'b0; rd_req = 1'b0;
    trig_addr = '0; cur_addr = '0; ans_wb = '0; ins = '0; last_exp = '0;
    tick(); tick();
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_armed", armed, 0);
    chk("rst_done", done, 0);
    chk("rst_wrapped", wrapped, 0);
    chk("rst_count", count, 0);
    reset = 1'b0;

    // Idle: stepping and read requests must not capture or produce data.
    for (int i = 0; i < 6; i++) begin
      step = 1'b1; cur_addr = DW'(i); rd_req = 1'b1;
      tick();
      chk("idle_armed", armed, 0);
      chk("idle_done", done, 0);
      chk("idle_count", count, 0);
      chk("idle_rd_valid", rd_valid, 0);
    end
    step = 1'b0; rd_req = 1'b0;

    vecs[0] = '{8'd5, 1'b0, 9,  8, 1'b1};
    vecs[1] = '{8'd2, 1'b0, 6,  6, 1'b0};
    vecs[2] = '{8'd4, 1'b0, 8,  8, 1'b0};
    vecs[3] = '{8'd7, 1'b0, 11, 8, 1'b1};
    vecs[4] = '{8'd4, 1'b1, 11, 6, 1'b0};
    vecs[5] = '{8'd0, 1'b0, 4,  4, 1'b0};

    for (int v = 0; v < 6; v++) begin
      trig_addr = vecs[v].trig;
      do_arm();
      capture(vecs[v].toggle, cyc);
      chk("cap_cycles", cyc, vecs[v].cycles);
      chk("cap_done", done, 1);
      chk("cap_armed", armed, 0);
      chk("cap_count", count, vecs[v].cnt);
      chk("cap_wrapped", wrapped, vecs[v].wrap);
      chk("cap_no_rd_valid", rd_valid, 0);
      read_n(vecs[v].cnt);
      chk("end_done", done, 0);
      chk("end_count", count, 0);
      chk("end_wrapped", wrapped, 0);
      chk("end_sb_left", sb.size(), 0);
      tick();
      chk("end_rd_valid_low", rd_valid, 0);
      chk("end_rd_data_hold", rd_data, last_exp);
    end

    // arm together with rd_req in DONE: arm wins, no read.
    trig_addr = 8'd5;
    do_arm();
    capture(1'b0, cyc);
    chk("ar_done", done, 1);
    arm = 1'b1; rd_req = 1'b1;
    tick();
    arm = 1'b0; rd_req = 1'b0;
    sb.delete();
    chk("ar_rd_valid", rd_valid, 0);
    chk("ar_armed", armed, 1);
    chk("ar_done_clr", done, 0);
    chk("ar_count", count, 0);
    tick();
    chk("ar_rd_valid_later", rd_valid, 0);

    // Reset in the middle of a readout with a request pending.
    capture(1'b0, cyc);
    chk("rr_done", done, 1);
    read_n(3);
    reset = 1'b1; rd_req = 1'b1;
    tick();
    chk("rr_rd_valid", rd_valid, 0);
    chk("rr_rd_data", rd_data, 0);
    chk("rr_armed", armed, 0);
    chk("rr_done0", done, 0);
    chk("rr_wrapped", wrapped, 0);
    chk("rr_count", count, 0);
    reset = 1'b0; rd_req = 1'b0;
    tick();
    chk("rr_rd_valid_after", rd_valid, 0);

    // Interrupt trigger with no post entries on the TRIG_IRQ instance.
    trig_addr = 8'hFF;
    do_arm();
    chk("irq_armed", armed2, 1);
    for (int a = 8'h1E; a <= 8'h21; a++) begin
      cur_addr  = DW'(a);
      interrupt = (a == 8'h21);
      ins       = IW'($urandom);
      ans_wb    = DW'($urandom);
      step      = 1'b1;
      e = {interrupt, cur_addr, ans_wb, ins};
      tick();
      sb2.push_back(e);
      chk("irq_done_timing", done2, (a == 8'h21));
    end
    step = 1'b0; interrupt = 1'b0;
    chk("irq_count", count2, 4);
    chk("irq_wrapped", wrapped2, 0);
    chk("irq_other_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1;
      tick();
      chk("irq_rd_valid", rd_valid2, 1);
      chk("irq_other_rd_valid", rd_valid, 0);
      if (sb2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL irq_sb_empty actual=entry required=none");
      end else begin
        chk("irq_rd_data", rd_data2, sb2.pop_front());
      end
    end
    rd_req = 1'b0;
    chk("irq_newest_bit", rd_data2[EW-1], 1);
    chk("irq_newest_addr", rd_data2[EW-2 -: DW], 8'h21);
    chk("irq_idle", done2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
